refresh_scheduler: RTL and testbench

Generates the periodic refresh traffic for the gain-cell DRAM array and sits directly upstream of the address-remapping table. It walks rows round-robin and performs a read/write-back on each row. While a refresh is in flight it publishes the row under refresh on ref_mem_addr, then pulses ref_done so the table can redirect and restore accesses. User traffic has priority until a deferral limit is reached; the block then stalls the user port and forces the refresh.

---
 rtl/refresh_scheduler.sv | 132 +++++++++++++
 tb/tb_refresh_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: periodic round-robin refresh of the gain-cell array.
// A timer raises a refresh request every REF_INTERVAL cycles. The request
// waits while user traffic is active, for at most MAX_DEFER idle-state
// cycles, then the user port is stalled and the row is read, captured and
// written back. ref_done pulses with ref_mem_addr still on the refreshed row.
//
// Handshake contract with the upstream arbiter: stall_o is a level, not a
// valid/ready pair. While stall_o=1 the arbiter must not issue user accesses.
// stall_o is decoded from registers only, so it never depends on user_req in
// the same cycle. user_req is only a hint that lets the refresh wait.
module refresh_scheduler #(
  parameter int ADDR_W       = 3,
  parameter int NUM_ROWS     = 8,
  parameter int DATA_W       = 8,
  parameter int REF_INTERVAL = 16,
  parameter int MAX_DEFER    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              user_req,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ref_mem_addr,
  output logic              ref_ren,
  output logic              ref_wen,
  output logic [DATA_W-1:0] ref_wdata,
  output logic              ref_done,
  output logic              ref_busy,
  output logic              stall_o,
  output logic              overrun
);

  localparam int TW = $clog2(REF_INTERVAL);
  localparam int DW = $clog2(MAX_DEFER + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TW-1:0]     timer;
  logic              pending;
  logic [DW-1:0]     defer_cnt;
  logic [ADDR_W-1:0] row;
  logic [DATA_W-1:0] wdata;
  logic              overrun_q;

  logic wrap;
  logic defer_max;
  logic start;

  assign wrap      = (timer == TW'(REF_INTERVAL - 1));
  assign defer_max = (defer_cnt == DW'(MAX_DEFER));
  // A pending refresh starts when the user is idle or has waited long enough.
  assign start     = pending && (!user_req || defer_max);

  // Free-running request timer, wraps at REF_INTERVAL-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= '0;
    else if (wrap) timer <= '0;
    else timer <= timer + TW'(1);
  end

  // Request flag: a new wrap wins over the clear on the DONE exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else if (wrap) pending <= 1'b1;
    else if (state == DONE) pending <= 1'b0;
  end

  // Sticky loss flag: a second request arrived before the first completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else if (wrap && pending && (state != DONE)) overrun_q <= 1'b1;
  end

  // Deferral counter: counts idle cycles a pending request spent yielding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) defer_cnt <= '0;
    else if (state == DONE) defer_cnt <= '0;
    else if ((state == IDLE) && pending && user_req && !defer_max)
      defer_cnt <= defer_cnt + DW'(1);
  end

  // Row pointer advances after each completed refresh, wrapping at NUM_ROWS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row <= '0;
    else if (state == DONE) begin
      if (row == ADDR_W'(NUM_ROWS - 1)) row <= '0;
      else row <= row + ADDR_W'(1);
    end
  end

  // Capture read data in CAPT; it is held for the write-back and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdata <= '0;
    else if (state == CAPT) wdata <= mem_rdata;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end

  // FSM next state: every non-IDLE state lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = CAPT;
      CAPT:    state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ref_ren      = (state == READ);
  assign ref_wen      = (state == WRITE);
  assign ref_done     = (state == DONE);
  assign ref_busy     = (state != IDLE);
  assign stall_o      = ref_busy | (pending & defer_max);
  assign ref_mem_addr = row;
  assign ref_wdata    = wdata;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb_refresh_scheduler: two instances (default timing, and a short-interval /
// long-deferral variant) checked every cycle against a cycle-count model,
// plus literal expectations at hand-computed cycles.
module tb_refresh_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic       rst_n_a, user_req_a;
  logic [7:0] mem_rdata_a;
  logic [2:0] addr_a;
  logic       ren_a, wen_a, done_a, busy_a, stall_a, ovr_a;
  logic [7:0] wdata_a;

  // Instance B: REF_INTERVAL=8, MAX_DEFER=12.
  logic       rst_n_b, user_req_b;
  logic [7:0] mem_rdata_b;
  logic [2:0] addr_b;
  logic       ren_b, wen_b, done_b, busy_b, stall_b, ovr_b;
  logic [7:0] wdata_b;

  refresh_scheduler dut_a (
    .clk(clk), .rst_n(rst_n_a), .user_req(user_req_a), .mem_rdata(mem_rdata_a),
    .ref_mem_addr(addr_a), .ref_ren(ren_a), .ref_wen(wen_a), .ref_wdata(wdata_a),
    .ref_done(done_a), .ref_busy(busy_a), .stall_o(stall_a), .overrun(ovr_a)
  );

  refresh_scheduler #(.REF_INTERVAL(8), .MAX_DEFER(12)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .user_req(user_req_b), .mem_rdata(mem_rdata_b),
    .ref_mem_addr(addr_b), .ref_ren(ren_b), .ref_wen(wen_b), .ref_wdata(wdata_b),
    .ref_done(done_b), .ref_busy(busy_b), .stall_o(stall_b), .overrun(ovr_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age counts cycles since the refresh started (1=read strobe,
  // 2=capture, 3=write strobe, 4=done pulse, 0=no refresh in flight).
  typedef struct packed {
    logic [31:0] cyc;
    logic        pending;
    logic [7:0]  defer;
    logic [7:0]  row;
    logic [2:0]  age;
    logic [7:0]  wdata;
    logic        overrun;
  } mstate_t;

  function automatic mstate_t model_step(input mstate_t s, input logic ureq,
                                         input logic [7:0] rd, input int interval,
                                         input int maxd, input int rows);
    mstate_t n;
    logic wrap;
    n = s;
    wrap = ((int'(s.cyc) % interval) == interval - 1);
    n.cyc = s.cyc + 32'd1;
    if (s.age == 3'd0) begin
      if (s.pending && (!ureq || int'(s.defer) == maxd)) n.age = 3'd1;
      else if (s.pending && int'(s.defer) < maxd) n.defer = s.defer + 8'd1;
    end else if (s.age == 3'd4) begin
      n.age = 3'd0;
      n.pending = 1'b0;
      n.defer = 8'd0;
      n.row = 8'((int'(s.row) + 1) % rows);
    end else begin
      if (s.age == 3'd2) n.wdata = rd;
      n.age = s.age + 3'd1;
    end
    if (wrap) begin
      if (s.pending && s.age != 3'd4) n.overrun = 1'b1;
      n.pending = 1'b1;
    end
    return n;
  endfunction

  mstate_t ma, mb;

  always @(posedge clk or negedge rst_n_a)
    if (!rst_n_a) ma <= '0;
    else ma <= model_step(ma, user_req_a, mem_rdata_a, 16, 4, 8);

  always @(posedge clk or negedge rst_n_b)
    if (!rst_n_b) mb <= '0;
    else mb <= model_step(mb, user_req_b, mem_rdata_b, 8, 12, 8);

  task automatic cmp_all(input string t, input mstate_t m, input int maxd,
                         input logic ren, input logic wen, input logic done,
                         input logic busy, input logic stall, input logic ovr,
                         input logic [2:0] addr, input logic [7:0] wd);
    logic stall_exp;
    stall_exp = (m.age != 3'd0) || (m.pending && int'(m.defer) == maxd);
    chk({t, "_ren"},   32'(ren),   32'(m.age == 3'd1));
    chk({t, "_wen"},   32'(wen),   32'(m.age == 3'd3));
    chk({t, "_done"},  32'(done),  32'(m.age == 3'd4));
    chk({t, "_busy"},  32'(busy),  32'(m.age != 3'd0));
    chk({t, "_stall"}, 32'(stall), 32'(stall_exp));
    chk({t, "_ovr"},   32'(ovr),   32'(m.overrun));
    chk({t, "_addr"},  32'(addr),  32'(m.row[2:0]));
    chk({t, "_wdata"}, 32'(wd),    32'(m.wdata));
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n_a) cmp_all("a", ma, 4, ren_a, wen_a, done_a, busy_a, stall_a, ovr_a, addr_a, wdata_a);
    if (rst_n_b) cmp_all("b", mb, 12, ren_b, wen_b, done_b, busy_b, stall_b, ovr_b, addr_b, wdata_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_a(input int n);
    int guard;
    guard = 0;
    while (int'(ma.cyc) < n && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) chk("goto_timeout", 32'(guard), 32'd0);
  endtask

  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];

  initial begin
    int guard;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    user_req_a = 1'b0; user_req_b = 1'b1;
    mem_rdata_a = 8'hA5; mem_rdata_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    // Reset state, cycle 0.
    chk("rst_ren",   32'(ren_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_addr",  32'(addr_a), 32'd0);
    chk("rst_ovr",   32'(ovr_a), 32'd0);

    // Idle user: first refresh timing, captured data, nine-row walk.
    guard = 0;
    while (int'(ma.cyc) < 149 && guard < 400) begin
      case (int'(ma.cyc))
        15: begin chk("c15_busy", 32'(busy_a), 32'd0); chk("c15_stall", 32'(stall_a), 32'd0); end
        17: begin chk("c17_ren", 32'(ren_a), 32'd1); chk("c17_addr", 32'(addr_a), 32'd0); end
        18: chk("c18_ren", 32'(ren_a), 32'd0);
        19: begin chk("c19_wen", 32'(wen_a), 32'd1); chk("c19_wdata", 32'(wdata_a), 32'hA5); end
        20: begin chk("c20_done", 32'(done_a), 32'd1); chk("c20_addr", 32'(addr_a), 32'd0); end
        21: begin chk("c21_addr", 32'(addr_a), 32'd1); chk("c21_done", 32'(done_a), 32'd0);
                  chk("c21_busy", 32'(busy_a), 32'd0); end
        34: chk("c34_wdata_hold", 32'(wdata_a), 32'hA5);
        default: ;
      endcase
      case (int'(mb.cyc))
        15: chk("b15_ovr", 32'(ovr_b), 32'd0);
        16: chk("b16_ovr", 32'(ovr_b), 32'd1);
        19: chk("b19_stall", 32'(stall_b), 32'd0);
        20: chk("b20_stall", 32'(stall_b), 32'd1);
        21: chk("b21_ren", 32'(ren_b), 32'd1);
        25: begin chk("b25_ovr", 32'(ovr_b), 32'd1); chk("b25_busy", 32'(busy_b), 32'd0); end
        default: ;
      endcase
      if (done_a) got_q.push_back(addr_a);
      if (int'(ma.cyc) >= 21) mem_rdata_a = 8'($urandom);
      mem_rdata_b = 8'($urandom);
      tick();
      guard++;
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    exp_q.push_back(3'd0);
    chk("walk_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("walk_addr", 32'(got_q[i]), 32'(exp_q[i]));

    // Busy user: deferral saturates, then the refresh is forced.
    user_req_a = 1'b1;
    goto_a(160); chk("d160_stall", 32'(stall_a), 32'd0);
    goto_a(163); chk("d163_stall", 32'(stall_a), 32'd0);
    goto_a(164); chk("d164_stall", 32'(stall_a), 32'd1); chk("d164_busy", 32'(busy_a), 32'd0);
    goto_a(165); chk("d165_ren", 32'(ren_a), 32'd1); chk("d165_stall", 32'(stall_a), 32'd1);
    goto_a(168); chk("d168_done", 32'(done_a), 32'd1); chk("d168_stall", 32'(stall_a), 32'd1);
    goto_a(169); chk("d169_stall", 32'(stall_a), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 430; i++) begin
      user_req_a = ($urandom_range(0, 3) != 0);
      mem_rdata_a = 8'($urandom);
      mem_rdata_b = 8'($urandom);
      tick();
    end

    // Asynchronous reset in the write-back cycle.
    user_req_a = 1'b0;
    guard = 0;
    while (ma.age != 3'd3 && guard < 60) begin
      tick();
      guard++;
    end
    chk("find_write", 32'(ma.age), 32'd3);
    #2;
    rst_n_a = 1'b0;
    #1;
    chk("arst_wen",   32'(wen_a), 32'd0);
    chk("arst_busy",  32'(busy_a), 32'd0);
    chk("arst_stall", 32'(stall_a), 32'd0);
    chk("arst_addr",  32'(addr_a), 32'd0);
    repeat (2) begin
      tick();
      chk("arst_nodone", 32'(done_a), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    goto_a(16); chk("r16_done", 32'(done_a), 32'd0);
    goto_a(17); chk("r17_ren", 32'(ren_a), 32'd1); chk("r17_addr", 32'(addr_a), 32'd0);
    goto_a(20); chk("r20_done", 32'(done_a), 32'd1); chk("r20_addr", 32'(addr_a), 32'd0);
    goto_a(21); chk("r21_addr", 32'(addr_a), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
